vam_divider: RTL and testbench

- Sequential unsigned restoring divider for the VAM-16 arithmetic unit. It is the inverse of the 8x8->16 multiplier datapath.
- Divides a 16-bit dividend by an 8-bit divisor, producing a 16-bit quotient and an 8-bit remainder. Each run takes WN iterations.
- Uses a start/busy/readyPulse handshake that matches the multiplier's readyPulse convention, so the controller can sequence multiply and divide identically.

---
 rtl/vam_divider.sv | 92 +++++++++
 tb/tb_vam_divider.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/vam_divider.sv
// vam_divider: sequential unsigned restoring divider (WN-bit dividend / WD-bit divisor)
// with a start/busy/readyPulse handshake shared with the multiplier.
module vam_divider #(
    parameter int WN = 16,
    parameter int WD = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [WN-1:0] inW,
    input  logic [WD-1:0] inB,
    output logic [WN-1:0] outQ,
    output logic [WD-1:0] outR,
    output logic          busy,
    output logic          divZero,
    output logic          readyPulse
);
    localparam int CW = $clog2(WN) + 1;
    localparam logic [CW-1:0] LAST = CW'(WN - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [WN-1:0] quo;
    logic [WD:0]   rem;
    logic [WD-1:0] dvs;
    logic [CW-1:0] count;
    logic [WD+1:0] trial;
    logic          fits;
    logic [WD:0]   nextRem;
    logic [WN-1:0] nextQuo;

    // The extra remainder bit keeps the trial subtract correct for divisors >= 2^(WD-1).
    always_comb begin
        trial   = {rem, quo[WN-1]} - {2'b00, dvs};
        fits    = ~trial[WD+1];
        nextRem = fits ? trial[WD:0] : {rem[WD-1:0], quo[WN-1]};
        nextQuo = {quo[WN-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            quo        <= '0;
            rem        <= '0;
            dvs        <= '0;
            count      <= '0;
            outQ       <= '0;
            outR       <= '0;
            busy       <= 1'b0;
            divZero    <= 1'b0;
            readyPulse <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    quo   <= inW;
                    dvs   <= inB;
                    rem   <= '0;
                    count <= '0;
                    busy  <= 1'b1;
                    if (inB == '0) begin
                        state      <= DONE;
                        outQ       <= '1;
                        outR       <= '0;
                        divZero    <= 1'b1;
                        readyPulse <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    quo   <= nextQuo;
                    rem   <= nextRem;
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        outQ       <= nextQuo;
                        outR       <= nextRem[WD-1:0];
                        divZero    <= 1'b0;
                        readyPulse <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    readyPulse <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vam_divider.sv
// tb_vam_divider: directed vectors, expected results queued by the driver and
// checked by a separate monitor on every readyPulse.
module tb_vam_divider;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] inW;
    logic [7:0]  inB;
    logic [15:0] outQ;
    logic [7:0]  outR;
    logic        busy, divZero, readyPulse;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    logic [15:0] lastQ = '0;

    vam_divider #(.WN(16), .WD(8)) dut (
        .clk(clk), .rst(rst), .start(start), .inW(inW), .inB(inB),
        .outQ(outQ), .outR(outR), .busy(busy), .divZero(divZero),
        .readyPulse(readyPulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    // Monitor: every readyPulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (readyPulse === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got readyPulse=1, expected 0 (nothing pending)");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("outQ", 32'(outQ), 32'(e.q));
                check("outR", 32'(outR), 32'(e.r));
                check("divZero", 32'(divZero), 32'(e.dz));
            end
        end
    end

    task automatic runDiv(input logic [15:0] w, input logic [7:0] b,
                          input logic [15:0] q, input logic [7:0] r, input logic dz);
        int n;
        @(negedge clk);
        inW = w;
        inB = b;
        start = 1'b1;
        sb.push_back('{q: q, r: r, dz: dz});
        n = 0;
        do begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (n == 8 && b != 0) begin
                check("busy_midrun", 32'(busy), 32'd1);
                check("outQ_held_midrun", 32'(outQ), 32'(lastQ));
            end
        end while (readyPulse !== 1'b1 && n < 100);
        check("latency", n, (b == 0) ? 1 : 17);
        @(negedge clk);
        check("pulse_one_cycle", 32'(readyPulse), 32'd0);
        check("idle_not_busy", 32'(busy), 32'd0);
        lastQ = q;
    endtask

    initial begin
        int pulses[$];
        int n;
        rst = 1'b1;
        start = 1'b0;
        inW = '0;
        inB = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_outQ", 32'(outQ), 32'd0);
        check("reset_outR", 32'(outR), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_divZero", 32'(divZero), 32'd0);
        check("reset_ready", 32'(readyPulse), 32'd0);

        runDiv(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
        runDiv(16'hFFFF, 8'hFF, 16'd257, 8'd0, 1'b0);
        runDiv(16'hFFFF, 8'h80, 16'd511, 8'h7F, 1'b0);
        runDiv(16'd5, 8'd16, 16'd0, 8'd5, 1'b0);
        runDiv(16'd0, 8'd3, 16'd0, 8'd0, 1'b0);
        runDiv(16'h1234, 8'd0, 16'hFFFF, 8'd0, 1'b1);
        runDiv(16'hABCD, 8'd60, 16'd733, 8'd1, 1'b0);

        // start held high: accepts at cycles 0, 18, 36 of the window
        @(negedge clk);
        inW = 16'd100;
        inB = 8'd9;
        start = 1'b1;
        repeat (3) sb.push_back('{q: 16'd11, r: 8'd1, dz: 1'b0});
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (readyPulse === 1'b1) pulses.push_back(i);
            if (i == 5) begin
                inW = 16'd999;
                inB = 8'd1;
            end
            if (i == 10) begin
                inW = 16'd100;
                inB = 8'd9;
            end
        end
        start = 1'b0;
        check("held_pulse_count", pulses.size(), 2);
        if (pulses.size() >= 2) check("held_pulse_gap", pulses[1] - pulses[0], 18);
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("held_drain", sb.size(), 0);
        repeat (2) @(negedge clk);
        lastQ = 16'd11;

        // reset mid-RUN aborts with no pulse
        @(negedge clk);
        inW = 16'd200;
        inB = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outQ", 32'(outQ), 32'd0);
        check("abort_outR", 32'(outR), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_divZero", 32'(divZero), 32'd0);
        repeat (20) @(negedge clk);
        lastQ = '0;
        runDiv(16'd300, 8'd10, 16'd30, 8'd0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
